ex_stage: RTL

Execute stage of the five-stage MIPS pipeline, directly downstream of the decode stage. It holds the ID/EX pipeline register and performs ALU operations, address generation, and single-cycle multiply. Division is iterative and stalls the front end. It drives data-SRAM requests and produces the EX/MEM bus plus an EX forwarding bus back to decode.

---
 rtl/ex_stage.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage MIPS pipeline.
//
// Holds the ID/EX pipeline register and computes the ALU result and load/store
// address. It runs single-cycle mult/multu, handles mthi/mtlo/mfhi/mflo, and
// runs an iterative radix-2 restoring divider that stalls the front end.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous reset, active low
//   stall[5:0]       pipeline stall bus; bit 2 = this stage, bit 3 = next stage
//   id_to_ex_bus     231-bit decode bundle (see field unpacking below)
//   ex_to_mem_bus    142-bit {hilo_bus, pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
//   ex_to_rf_bus     104-bit forwarding bus {hilo_bus, rf_we, rf_waddr, ex_result}
//   data_sram_*      data memory request (enable, byte write enables, address, store data)
//   inst_is_load     instruction in EX writes a register from memory
//   stallreq_for_ex  divider busy; front end must hold
module ex_stage #(
    parameter int DIV_CYCLES = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic [230:0] id_to_ex_bus,
    output logic [141:0] ex_to_mem_bus,
    output logic [103:0] ex_to_rf_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_wen,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic         inst_is_load,
    output logic         stallreq_for_ex
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

    logic [230:0] id_ex_q;

    // ID/EX register: a stall here with the next stage running inserts a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_ex_q <= '0;
        end else if (stall[2] && !stall[3]) begin
            id_ex_q <= '0;
        end else if (!stall[2]) begin
            id_ex_q <= id_to_ex_bus;
        end
    end

    logic [7:0]  hilo_op;
    logic [31:0] hi_fwd, lo_fwd, pc, inst, rdata1, rdata2;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en, rf_we, sel_rf_res;
    logic [3:0]  ram_wen;
    logic [4:0]  rf_waddr;

    assign {hilo_op, hi_fwd, lo_fwd, pc, inst, alu_op, sel_src1, sel_src2,
            ram_en, ram_wen, rf_we, rf_waddr, sel_rf_res, rdata1, rdata2} = id_ex_q;

    logic op_mfhi, op_mflo, op_mthi, op_mtlo, op_mult, op_multu, op_div, op_divu;
    assign {op_mfhi, op_mflo, op_mthi, op_mtlo, op_mult, op_multu, op_div, op_divu} = hilo_op;

    logic [15:0] imm;
    logic [31:0] src1, src2;
    assign imm = inst[15:0];

    // Selects are one-hot, so an AND-OR mux is enough and all-zero yields 0.
    always_comb begin
        src1 = ({32{sel_src1[0]}} & rdata1)
             | ({32{sel_src1[1]}} & pc)
             | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});
        src2 = ({32{sel_src2[0]}} & rdata2)
             | ({32{sel_src2[1]}} & {{16{imm[15]}}, imm})
             | ({32{sel_src2[2]}} & 32'd8)
             | ({32{sel_src2[3]}} & {16'b0, imm});
    end

    logic [4:0]  shamt;
    logic [31:0] alu_res;
    assign shamt = src1[4:0];

    always_comb begin
        alu_res = 32'b0;
        if      (alu_op[11]) alu_res = src1 + src2;
        else if (alu_op[10]) alu_res = src1 - src2;
        else if (alu_op[9])  alu_res = {31'b0, $signed(src1) < $signed(src2)};
        else if (alu_op[8])  alu_res = {31'b0, src1 < src2};
        else if (alu_op[7])  alu_res = src1 & src2;
        else if (alu_op[6])  alu_res = ~(src1 | src2);
        else if (alu_op[5])  alu_res = src1 | src2;
        else if (alu_op[4])  alu_res = src1 ^ src2;
        else if (alu_op[3])  alu_res = src2 << shamt;
        else if (alu_op[2])  alu_res = src2 >> shamt;
        else if (alu_op[1])  alu_res = $signed(src2) >>> shamt;
        else if (alu_op[0])  alu_res = {src2[15:0], 16'b0};
    end

    // Operands are widened explicitly so the low 64 bits are the true product.
    logic [63:0] prod_s, prod_u;
    assign prod_s = {{32{rdata1[31]}}, rdata1} * {{32{rdata2[31]}}, rdata2};
    assign prod_u = {32'b0, rdata1} * {32'b0, rdata2};

    // Divider: operands come straight from the held ID/EX register.
    logic        is_div, dvd_neg, dvs_neg;
    logic [31:0] dvd_mag, dvs_mag;
    assign is_div  = op_div | op_divu;
    assign dvd_neg = op_div & rdata1[31];
    assign dvs_neg = op_div & rdata2[31];
    assign dvd_mag = dvd_neg ? (~rdata1 + 32'd1) : rdata1;
    assign dvs_mag = dvs_neg ? (~rdata2 + 32'd1) : rdata2;

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      quo_q, rem_q, dvsr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (is_div) state_d = DIV_BUSY;
            DIV_BUSY: if (cnt_q == CNT_W'(DIV_CYCLES - 1)) state_d = DIV_DONE;
            DIV_DONE: if (!stall[3]) state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. When it fits the
    // difference is below the divisor, so 32 bits of it suffice.
    logic [32:0] shifted;
    logic        step_ge;
    logic [31:0] step_sub;
    assign shifted  = {rem_q, quo_q[31]};
    assign step_ge  = shifted >= {1'b0, dvsr_q};
    assign step_sub = shifted[31:0] - dvsr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (is_div) begin
                        quo_q  <= dvd_mag;
                        rem_q  <= '0;
                        dvsr_q <= dvs_mag;
                        cnt_q  <= '0;
                    end
                end
                DIV_BUSY: begin
                    quo_q <= {quo_q[30:0], step_ge};
                    rem_q <= step_ge ? step_sub : shifted[31:0];
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    logic [31:0] div_lo, div_hi;
    always_comb begin
        if (rdata2 == 32'b0) begin
            div_lo = 32'hFFFF_FFFF;
            div_hi = rdata1;
        end else begin
            div_lo = (dvd_neg ^ dvs_neg) ? (~quo_q + 32'd1) : quo_q;
            div_hi = dvd_neg ? (~rem_q + 32'd1) : rem_q;
        end
    end

    logic        hi_we, lo_we;
    logic [31:0] hi_val, lo_val;
    always_comb begin
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        hi_val = 32'b0;
        lo_val = 32'b0;
        if (op_mthi) begin
            hi_we  = 1'b1;
            hi_val = rdata1;
        end
        if (op_mtlo) begin
            lo_we  = 1'b1;
            lo_val = rdata1;
        end
        if (op_mult || op_multu) begin
            hi_we  = 1'b1;
            lo_we  = 1'b1;
            hi_val = op_mult ? prod_s[63:32] : prod_u[63:32];
            lo_val = op_mult ? prod_s[31:0]  : prod_u[31:0];
        end
        if (is_div && state_q == DIV_DONE) begin
            hi_we  = 1'b1;
            lo_we  = 1'b1;
            hi_val = div_hi;
            lo_val = div_lo;
        end
    end

    logic [65:0] hilo_bus;
    logic [31:0] ex_result;
    assign hilo_bus  = {hi_we, hi_val, lo_we, lo_val};
    assign ex_result = op_mfhi ? hi_fwd : (op_mflo ? lo_fwd : alu_res);

    assign stallreq_for_ex = (state_q == DIV_IDLE && is_div) || (state_q == DIV_BUSY);

    assign data_sram_en    = ram_en & ~stallreq_for_ex;
    assign data_sram_wen   = ram_wen & {4{data_sram_en}};
    assign data_sram_addr  = alu_res;
    assign data_sram_wdata = rdata2;
    assign inst_is_load    = ram_en & sel_rf_res;

    assign ex_to_mem_bus = {hilo_bus, pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
    assign ex_to_rf_bus  = {hilo_bus, rf_we, rf_waddr, ex_result};

    logic unused_bits;
    assign unused_bits = &{1'b0, stall[5:4], stall[1:0], inst[31:16]};

endmodule
